// File: rtl/tt_sweep_capture.sv
`default_nettype none
// ============================================================================
// Module   : tt_sweep_capture
// Purpose  : Truth-table capture engine for a NUM_INPUTS-input, single-output
//            combinational function. Walks every input vector, samples the
//            function output, assembles the full table and compares it
//            against an expected table latched at start.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                 in   1       rising-edge clock
//   rst_n               in   1       asynchronous active-low reset
//   start               in   1       begin sweep (accepted only in IDLE)
//   abort               in   1       terminate sweep, results invalidated
//   expected_tt         in   TT_W    expected table, latched at start
//   x_out               out  N       vector driven to the function
//   f_in                in   1       function output
//   busy                out  1       sweep in progress
//   done                out  1       one-cycle pulse, sweep completed
//   results_valid       out  1       results belong to last completed sweep
//   tt_out              out  TT_W    captured table, bit i = f(x_out=i)
//   match               out  1       tt_out == expected table
//   mismatch_count      out  N+1     number of differing bits
//   first_mismatch_idx  out  N       lowest differing index (0 if none)
// ============================================================================
module tt_sweep_capture #(
  parameter  int NUM_INPUTS    = 7,
  parameter  int SETTLE_CYCLES = 1,
  localparam int TT_W          = 2 ** NUM_INPUTS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [TT_W-1:0]       expected_tt,
  output logic [NUM_INPUTS-1:0] x_out,
  input  logic                  f_in,
  output logic                  busy,
  output logic                  done,
  output logic                  results_valid,
  output logic [TT_W-1:0]       tt_out,
  output logic                  match,
  output logic [NUM_INPUTS:0]   mismatch_count,
  output logic [NUM_INPUTS-1:0] first_mismatch_idx
);

  localparam int CNT_W = NUM_INPUTS + 1;
  localparam int SC_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SC_W-1:0]       SETTLE_LAST =
    SC_W'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);
  localparam logic [NUM_INPUTS-1:0] IDX_LAST    = {NUM_INPUTS{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_SAMPLE = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [TT_W-1:0] exp_q;
  logic [SC_W-1:0] settle_cnt;
  logic            accept;
  logic            bit_differs;

  // start is only honoured in IDLE and loses to a simultaneous abort
  assign accept      = (state == S_IDLE) && start && !abort;
  assign bit_differs = f_in != exp_q[x_out];

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and status decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          // With no settle time the HOLD state is skipped entirely
          state_next = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_HOLD;
        end
      end
      S_HOLD: begin
        busy = 1'b1;
        if (abort) begin
          state_next = S_IDLE;
        end else if (settle_cnt == SETTLE_LAST) begin
          state_next = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        busy = 1'b1;
        if (abort) begin
          state_next = S_IDLE;
        end else if (x_out == IDX_LAST) begin
          state_next = S_FINISH;
        end else begin
          state_next = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_HOLD;
        end
      end
      S_FINISH: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // match is only meaningful once a sweep has completed
  assign match = results_valid && (mismatch_count == '0);

  // --------------------------------------------------------------------------
  // Datapath: vector index (doubles as x_out), capture and comparison
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q              <= '0;
      tt_out             <= '0;
      x_out              <= '0;
      settle_cnt         <= '0;
      mismatch_count     <= '0;
      first_mismatch_idx <= '0;
      results_valid      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            exp_q              <= expected_tt;
            tt_out             <= '0;
            x_out              <= '0;
            settle_cnt         <= '0;
            mismatch_count     <= '0;
            first_mismatch_idx <= '0;
            results_valid      <= 1'b0;
          end
        end
        S_HOLD: begin
          if (abort) begin
            x_out         <= '0;
            settle_cnt    <= '0;
            results_valid <= 1'b0;
          end else if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + SC_W'(1);
          end
        end
        S_SAMPLE: begin
          if (abort) begin
            x_out         <= '0;
            results_valid <= 1'b0;
          end else begin
            tt_out[x_out] <= f_in;
            if (bit_differs) begin
              mismatch_count <= mismatch_count + CNT_W'(1);
              if (mismatch_count == '0) begin
                first_mismatch_idx <= x_out;
              end
            end
            // The last vector's increment wraps the index back to 0,
            // which is exactly the x_out value wanted in FINISH/IDLE
            x_out <= x_out + NUM_INPUTS'(1);
            if (x_out == IDX_LAST) begin
              results_valid <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tt_sweep_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_tt_sweep_capture
// Purpose  : Directed self-checking bench for tt_sweep_capture. Instance u0
//            uses SETTLE_CYCLES=1 driven by a table-lookup fixture function
//            (or a constant 0); instance u1 uses SETTLE_CYCLES=0 driven by an
//            x6 buffer.
// Revision : 1.0  initial release
// ============================================================================
module tb_tt_sweep_capture;

  logic         clk;
  logic         rst_n;

  // instance 0 (SETTLE_CYCLES = 1)
  logic         start0, abort0, f0, busy0, done0, rv0, match0;
  logic [127:0] exp0, tt0;
  logic [6:0]   x0, first0;
  logic [7:0]   cnt0;

  // instance 1 (SETTLE_CYCLES = 0)
  logic         start1, abort1, f1, busy1, done1, rv1, match1;
  logic [127:0] exp1, tt1;
  logic [6:0]   x1, first1;
  logic [7:0]   cnt1;

  logic [127:0] fix_tt;
  logic [127:0] half_tt;
  logic         tie0;
  int           errors;
  int           checks;
  int           cyc;
  logic         saw_done;

  assign f0 = tie0 ? 1'b0 : fix_tt[x0];
  assign f1 = x1[6];

  tt_sweep_capture #(.NUM_INPUTS(7), .SETTLE_CYCLES(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
    .expected_tt(exp0), .x_out(x0), .f_in(f0), .busy(busy0), .done(done0),
    .results_valid(rv0), .tt_out(tt0), .match(match0),
    .mismatch_count(cnt0), .first_mismatch_idx(first0)
  );

  tt_sweep_capture #(.NUM_INPUTS(7), .SETTLE_CYCLES(0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .expected_tt(exp1), .x_out(x1), .f_in(f1), .busy(busy1), .done(done1),
    .results_valid(rv1), .tt_out(tt1), .match(match1),
    .mismatch_count(cnt1), .first_mismatch_idx(first1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Raise start at a negedge; it is accepted by the next posedge (E0)
  task automatic start_u0();
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
  endtask

  task automatic start_u1();
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
  endtask

  // Returns the cycle number after E0 in which done is seen high
  task automatic wait_done0(output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!done0 && c < 2000);
  endtask

  task automatic wait_done1(output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!done1 && c < 2000);
  endtask

  task automatic wait_x0(input logic [6:0] v);
    int n;
    n = 0;
    while (x0 !== v && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_x_out", x0, v);
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    fix_tt  = 128'hfefefea8fec8e880fee8ec80ea808080;
    half_tt = {{64{1'b1}}, {64{1'b0}}};
    tie0    = 1'b0;
    start0  = 1'b0; abort0 = 1'b0; exp0 = '0;
    start1  = 1'b0; abort1 = 1'b0; exp1 = '0;
    rst_n   = 1'b0;

    // ---------------- reset state ----------------
    #1;
    chk("rst_x_out", x0, 7'd0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_rv", rv0, 1'b0);
    chk("rst_tt", tt0, 128'd0);
    chk("rst_cnt", cnt0, 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // ---------------- test 1: fixture function, exact match ----------------
    exp0 = fix_tt;
    start_u0();
    exp0 = '0;  // must not affect the sweep already accepted
    @(negedge clk);
    chk("t1_busy_c1", busy0, 1'b1);
    chk("t1_x_c1", x0, 7'd0);
    cyc = 1;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done0 && cyc < 2000);
    chk("t1_done_cycle", cyc, 257);
    chk("t1_tt", tt0, fix_tt);
    chk("t1_match", match0, 1'b1);
    chk("t1_cnt", cnt0, 8'd0);
    chk("t1_rv", rv0, 1'b1);
    chk("t1_busy_fin", busy0, 1'b0);
    chk("t1_x_fin", x0, 7'd0);

    // start raised during the done cycle: ignored on that edge
    exp0   = fix_tt ^ (128'd1 << 5) ^ (128'd1 << 100);
    start0 = 1'b1;
    @(negedge clk);
    chk("t1_start_in_done_busy", busy0, 1'b0);
    chk("t1_start_in_done_rv", rv0, 1'b1);
    chk("t1_done_one_cycle", done0, 1'b0);

    // ---------------- test 2: two expected bits inverted ----------------
    @(posedge clk);  // accepted here (E0)
    #1 start0 = 1'b0;
    wait_done0(cyc);
    chk("t2_done_cycle", cyc, 257);
    chk("t2_tt", tt0, fix_tt);
    chk("t2_match", match0, 1'b0);
    chk("t2_cnt", cnt0, 8'd2);
    chk("t2_first", first0, 7'd5);

    // ---------------- test 3: f tied 0 vs all-ones ----------------
    tie0 = 1'b1;
    exp0 = {128{1'b1}};
    start_u0();
    wait_done0(cyc);
    chk("t3_tt", tt0, 128'd0);
    chk("t3_cnt", cnt0, 8'h80);
    chk("t3_first", first0, 7'd0);
    chk("t3_match", match0, 1'b0);
    tie0 = 1'b0;

    // abort in IDLE has no effect; results hold
    @(negedge clk);
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_abort_rv", rv0, 1'b1);
    chk("idle_abort_cnt", cnt0, 8'h80);

    // ---------------- test 4: x6 buffer, SETTLE_CYCLES=0 ----------------
    exp1 = half_tt;
    start_u1();
    wait_done1(cyc);
    chk("t4_done_cycle", cyc, 129);
    chk("t4_tt", tt1, half_tt);
    chk("t4_match", match1, 1'b1);
    exp1 = '0;
    start_u1();
    wait_done1(cyc);
    chk("t4b_cnt", cnt1, 8'd64);
    chk("t4b_first", first1, 7'd64);
    chk("t4b_match", match1, 1'b0);

    // ---------------- test 5: restart ignored, then abort ----------------
    exp0 = fix_tt;
    start_u0();
    wait_x0(7'd40);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("t5_restart_busy", busy0, 1'b1);
    chk("t5_restart_x", x0, 7'd40);
    wait_x0(7'd60);
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    chk("t5_abort_busy", busy0, 1'b0);
    chk("t5_abort_x", x0, 7'd0);
    chk("t5_abort_rv", rv0, 1'b0);
    saw_done = done0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      saw_done = saw_done | done0;
    end
    chk("t5_no_done", saw_done, 1'b0);
    start_u0();
    wait_done0(cyc);
    chk("t5_fresh_cycle", cyc, 257);
    chk("t5_fresh_match", match0, 1'b1);

    // ---------------- test 6: async reset mid-sweep ----------------
    exp0 = ~fix_tt;
    start_u0();
    wait_x0(7'd90);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_x", x0, 7'd0);
    chk("t6_busy", busy0, 1'b0);
    chk("t6_tt", tt0, 128'd0);
    chk("t6_cnt", cnt0, 8'd0);
    chk("t6_rv", rv0, 1'b0);
    chk("t6_done", done0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_u0();
    wait_done0(cyc);
    chk("t6_after_cycle", cyc, 257);
    chk("t6_after_cnt", cnt0, 8'h80);
    chk("t6_after_tt", tt0, fix_tt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
